// File: rtl/ccff_loader.sv
// Streams bitstream bytes into a ccff configuration chain, MSB first,
// with optional readback of the bits leaving the chain tail.
module ccff_loader #(
   parameter int CHAIN_LEN = 16,
   parameter int CNT_W     = 16
) (
   input  logic             prog_clk,
   input  logic             pReset,
   input  logic             start,
   input  logic             rb_en,
   input  logic             in_valid,
   input  logic [7:0]       in_data,
   output logic             in_ready,
   output logic             ccff_head,
   output logic             chain_clk_en,
   input  logic             ccff_tail,
   output logic             out_valid,
   output logic [7:0]       out_data,
   input  logic             out_ready,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] bit_count
);

   typedef enum logic [1:0] {IDLE, FETCH, SHIFT, DONE} state_t;

   localparam logic [CNT_W-1:0] LEN = CNT_W'(CHAIN_LEN);

   state_t           state;
   state_t           state_nxt;
   logic [7:0]       shift_q;
   logic [2:0]       idx_q;
   logic             rb_q;
   logic [7:0]       rb_sr;
   logic [2:0]       rb_cnt;
   logic [CNT_W-1:0] cnt_inc;
   logic             last_bit;
   logic             rb_push;
   logic             stall;
   logic [7:0]       rb_cap;
   logic [7:0]       rb_just;

   assign cnt_inc  = bit_count + 1'b1;
   assign last_bit = (cnt_inc == LEN);
   assign rb_cap   = {rb_sr[6:0], ccff_tail};
   // a partial final byte is left-justified, zero-padded
   assign rb_just  = rb_cap << (3'd7 - rb_cnt);

   always_comb begin
      state_nxt    = state;
      in_ready     = 1'b0;
      ccff_head    = 1'b0;
      chain_clk_en = 1'b0;
      rb_push      = 1'b0;
      stall        = 1'b0;
      done         = 1'b0;
      busy         = (state != IDLE);
      unique case (state)
         IDLE: begin
            if (start) state_nxt = FETCH;
         end
         FETCH: begin
            in_ready = 1'b1;
            if (in_valid) state_nxt = SHIFT;
         end
         SHIFT: begin
            ccff_head    = shift_q[idx_q];
            rb_push      = rb_q & ((rb_cnt == 3'd7) | last_bit);
            stall        = rb_push & out_valid & ~out_ready;
            chain_clk_en = ~stall;
            if (chain_clk_en) begin
               if (last_bit)
                  state_nxt = DONE;
               else if (idx_q == 3'd0)
                  state_nxt = FETCH;
            end
         end
         DONE: begin
            if (!out_valid) begin
               done      = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge prog_clk or posedge pReset) begin
      if (pReset) begin
         state     <= IDLE;
         shift_q   <= '0;
         idx_q     <= '0;
         rb_q      <= 1'b0;
         rb_sr     <= '0;
         rb_cnt    <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         bit_count <= '0;
      end else begin
         state <= state_nxt;
         if (state == IDLE && start) begin
            bit_count <= '0;
            rb_q      <= rb_en;
            rb_sr     <= '0;
            rb_cnt    <= '0;
         end
         if (in_valid && in_ready) begin
            shift_q <= in_data;
            idx_q   <= 3'd7;
         end
         if (chain_clk_en) begin
            bit_count <= cnt_inc;
            idx_q     <= idx_q - 1'b1;
            if (rb_push) begin
               rb_sr  <= '0;
               rb_cnt <= '0;
            end else if (rb_q) begin
               rb_sr  <= rb_cap;
               rb_cnt <= rb_cnt + 1'b1;
            end
         end
         if (out_valid && out_ready) out_valid <= 1'b0;
         // push wins over a same-cycle pop
         if (chain_clk_en && rb_push) begin
            out_valid <= 1'b1;
            out_data  <= rb_just;
         end
      end
   end

endmodule

// File: tb/tb_ccff_loader.sv
// Bench for ccff_loader: two instances (16- and 12-bit chains)
// checked against a bit-queue model of the chain and bitstream.
module tb_ccff_loader;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        start;
   logic        rb_en;
   logic        in_valid;
   logic [7:0]  in_data;
   logic        out_ready;
   logic        rb_en_b;
   logic        out_ready_b;

   logic        in_ready, head, cen, ov, busy, done;
   logic [7:0]  od;
   logic [15:0] bc;
   logic        tail_a;

   logic        in_ready_b, head_b, cen_b, ov_b, busy_b, done_b;
   logic [7:0]  od_b;
   logic [15:0] bc_b;
   logic        tail_b;

   ccff_loader #(.CHAIN_LEN(16), .CNT_W(16)) dut_a (
      .prog_clk(clk), .pReset(rst), .start(start), .rb_en(rb_en),
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .ccff_head(head), .chain_clk_en(cen), .ccff_tail(tail_a),
      .out_valid(ov), .out_data(od), .out_ready(out_ready),
      .busy(busy), .done(done), .bit_count(bc)
   );

   ccff_loader #(.CHAIN_LEN(12), .CNT_W(16)) dut_b (
      .prog_clk(clk), .pReset(rst), .start(start), .rb_en(rb_en_b),
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready_b),
      .ccff_head(head_b), .chain_clk_en(cen_b), .ccff_tail(tail_b),
      .out_valid(ov_b), .out_data(od_b), .out_ready(out_ready_b),
      .busy(busy_b), .done(done_b), .bit_count(bc_b)
   );

   // external chain models; head enters bit 0, tail is the MSB
   logic [15:0] chain_a;
   logic [11:0] chain_b;
   logic        pre_req;
   logic [15:0] pre_val;

   always @(posedge clk) begin
      if (pre_req) chain_a <= pre_val;
      else if (cen) chain_a <= {chain_a[14:0], head};
      if (cen_b) chain_b <= {chain_b[10:0], head_b};
   end

   assign tail_a = chain_a[15];
   assign tail_b = chain_b[11];

   bit         exp_a[$];
   bit         exp_b[$];
   logic [7:0] exp_rb[$];
   logic [7:0] got_rb[$];
   logic [7:0] bs[2];
   int pos_a, pos_b, rpos, dn_a, dn_b, stalls, fc, ovc;
   int checks = 0;
   int errors = 0;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         chk("excl_a", {31'd0, in_ready & cen}, 0);
         if (cen) begin
            if (pos_a < exp_a.size())
               chk("head_a", {31'd0, head}, {31'd0, exp_a[pos_a]});
            else
               chk("extra_shift_a", pos_a, exp_a.size());
            pos_a++;
         end
         if (cen_b) begin
            if (pos_b < exp_b.size())
               chk("head_b", {31'd0, head_b}, {31'd0, exp_b[pos_b]});
            else
               chk("extra_shift_b", pos_b, exp_b.size());
            pos_b++;
         end
         if (ov && out_ready) begin
            got_rb.push_back(od);
            if (rpos < exp_rb.size())
               chk("rb_byte", {24'd0, od}, {24'd0, exp_rb[rpos]});
            else
               chk("extra_rb", rpos, exp_rb.size());
            rpos++;
         end
         if (done) dn_a++;
         if (done_b) dn_b++;
         if (in_ready) fc++;
         if (ov) ovc++;
         if (busy && !cen && !in_ready && !done && ov && !out_ready)
            stalls++;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic prep(input logic [7:0] b0, input logic [7:0] b1,
                       input bit rb, input logic [15:0] init);
      bs[0] = b0;
      bs[1] = b1;
      exp_a.delete();
      exp_b.delete();
      exp_rb.delete();
      got_rb.delete();
      pos_a = 0; pos_b = 0; rpos = 0; dn_a = 0; dn_b = 0;
      stalls = 0; fc = 0; ovc = 0;
      for (int i = 0; i < 2; i++)
         for (int k = 7; k >= 0; k--) begin
            if (exp_a.size() < 16) exp_a.push_back(bs[i][k]);
            if (exp_b.size() < 12) exp_b.push_back(bs[i][k]);
         end
      rb_en = rb;
      if (rb) begin
         exp_rb.push_back(init[15:8]);
         exp_rb.push_back(init[7:0]);
         pre_val = init;
         pre_req = 1'b1;
         tick();
         pre_req = 1'b0;
      end
   endtask

   task automatic run(input int gap, input bit mid_start);
      int n;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 2; i++) begin
         n = 0;
         while (!in_ready && n < 100) begin
            tick();
            n++;
         end
         chk("fetch_wait", {31'd0, n < 100}, 1);
         if (i > 0) repeat (gap) tick();
         in_valid = 1'b1;
         in_data  = bs[i];
         if (mid_start && i == 0) start = 1'b1;
         tick();
         in_valid = 1'b0;
         start    = 1'b0;
      end
      n = 0;
      while (dn_a == 0 && n < 200) begin
         tick();
         n++;
      end
      chk("done_wait", {31'd0, n < 200}, 1);
      repeat (3) tick();
   endtask

   task automatic finish_load(input int fc_exp);
      logic [15:0] wa;
      logic [11:0] wb;
      wa = '0;
      wb = '0;
      foreach (exp_a[i]) wa = {wa[14:0], exp_a[i]};
      foreach (exp_b[i]) wb = {wb[10:0], exp_b[i]};
      chk("done_pulses_a", dn_a, 1);
      chk("done_pulses_b", dn_b, 1);
      chk("shifts_a", pos_a, 16);
      chk("shifts_b", pos_b, 12);
      chk("bit_count_a", {16'd0, bc}, 16);
      chk("bit_count_b", {16'd0, bc_b}, 12);
      chk("chain_a", {16'd0, chain_a}, {16'd0, wa});
      chk("chain_b", {20'd0, chain_b}, {20'd0, wb});
      chk("rb_count", rpos, exp_rb.size());
      chk("fetch_cycles", fc, fc_exp);
      chk("busy_idle", {31'd0, busy}, 0);
      chk("ov_b", {31'd0, ov_b}, 0);
   endtask

   initial begin
      int n;
      rst = 1'b1;
      start = 1'b0; rb_en = 1'b0; in_valid = 1'b0; in_data = '0;
      out_ready = 1'b1; rb_en_b = 1'b0; out_ready_b = 1'b1;
      pre_req = 1'b0; pre_val = '0;
      repeat (3) tick();
      chk("rst_busy", {31'd0, busy}, 0);
      chk("rst_in_ready", {31'd0, in_ready}, 0);
      chk("rst_clk_en", {31'd0, cen}, 0);
      chk("rst_bit_count", {16'd0, bc}, 0);
      chk("rst_out_valid", {31'd0, ov}, 0);
      rst = 1'b0;
      tick();

      // gapless two-byte load, no readback
      prep(8'hA5, 8'h3C, 1'b0, 16'h0);
      run(0, 1'b0);
      finish_load(2);
      chk("chain_a5_3c", {16'd0, chain_a}, 32'hA53C);
      chk("chain_b_a53", {20'd0, chain_b}, 32'hA53);

      // short chain discards the tail of the second byte
      prep(8'hFF, 8'h0F, 1'b0, 16'h0);
      run(0, 1'b0);
      finish_load(2);
      chk("chain_b_ff0", {20'd0, chain_b}, 32'hFF0);
      chk("bc_b_12", {16'd0, bc_b}, 12);

      // readback of preloaded contents, consumer always ready
      prep(8'h12, 8'h34, 1'b1, 16'hBEEF);
      run(0, 1'b0);
      finish_load(2);
      chk("rb_first", {24'd0, got_rb[0]}, 32'hBE);
      chk("rb_second", {24'd0, got_rb[1]}, 32'hEF);
      chk("ov_cycles", ovc, 2);
      chk("no_stall", stalls, 0);

      // consumer withholds out_ready: final byte stalls the chain
      prep(8'h12, 8'h34, 1'b1, 16'hC0DE);
      fork
         run(0, 1'b0);
         begin
            n = 0;
            while (!ov && n < 100) begin
               tick();
               n++;
            end
            out_ready = 1'b0;
            n = 0;
            while (stalls < 5 && n < 100) begin
               tick();
               n++;
            end
            chk("stall_wait", {31'd0, n < 100}, 1);
            out_ready = 1'b1;
         end
      join
      finish_load(2);
      chk("stall_cycles", stalls, 5);
      chk("chain_1234", {16'd0, chain_a}, 32'h1234);
      chk("rb_c0", {24'd0, got_rb[0]}, 32'hC0);
      chk("rb_de", {24'd0, got_rb[1]}, 32'hDE);

      // gapped input plus a start while busy
      prep(8'hA5, 8'h3C, 1'b0, 16'h0);
      run(3, 1'b1);
      finish_load(5);
      chk("chain_gap_a53c", {16'd0, chain_a}, 32'hA53C);

      // reset part-way through the first byte
      prep(8'h5A, 8'hC3, 1'b0, 16'h0);
      start = 1'b1;
      tick();
      start = 1'b0;
      in_valid = 1'b1;
      in_data = 8'h5A;
      tick();
      in_valid = 1'b0;
      n = 0;
      while (pos_a < 6 && n < 50) begin
         tick();
         n++;
      end
      chk("mid_wait", {31'd0, n < 50}, 1);
      rst = 1'b1;
      #1;
      chk("ar_in_ready", {31'd0, in_ready}, 0);
      chk("ar_head", {31'd0, head}, 0);
      chk("ar_clk_en", {31'd0, cen}, 0);
      chk("ar_out_valid", {31'd0, ov}, 0);
      chk("ar_out_data", {24'd0, od}, 0);
      chk("ar_busy", {31'd0, busy}, 0);
      chk("ar_done", {31'd0, done}, 0);
      chk("ar_bit_count", {16'd0, bc}, 0);
      repeat (2) tick();
      rst = 1'b0;
      tick();
      prep(8'h5A, 8'hC3, 1'b0, 16'h0);
      run(0, 1'b0);
      finish_load(2);
      chk("chain_5ac3", {16'd0, chain_a}, 32'h5AC3);

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
